// File: rtl/bsg_dmc_pkg.sv
// Shared DMC configuration types: the bsg_dmc_s struct, the tag payload layout
// for the fourteen config nodes, and the state encodings of the tag sender.
package bsg_dmc_pkg;

  localparam int dmc_cfg_num_nodes_c      = 14;
  localparam int dmc_cfg_payload_width_c  = 8;
  localparam int dmc_cfg_sys_reset_node_c = 12;
  localparam int dmc_cfg_stall_node_c     = 13;

  typedef struct packed {
    logic [15:0] trefi;
    logic [3:0]  tmrd;
    logic [3:0]  trfc;
    logic [3:0]  trc;
    logic [3:0]  trp;
    logic [3:0]  tras;
    logic [3:0]  trrd;
    logic [3:0]  trcd;
    logic [3:0]  twr;
    logic [3:0]  twtr;
    logic [3:0]  trtp;
    logic [3:0]  tcas;
    logic [3:0]  col_width;
    logic [3:0]  row_width;
    logic [1:0]  bank_width;
    logic [5:0]  bank_pos;
    logic [2:0]  dqs_sel_cal;
    logic [15:0] init_cycles;
  } bsg_dmc_s;

  typedef logic [dmc_cfg_num_nodes_c-1:0][dmc_cfg_payload_width_c-1:0] bsg_dmc_cfg_payload_s;

  // Bit-level packet states; the line always carries the field named by the state.
  typedef enum logic [2:0] {
    TAG_IDLE,
    TAG_START,
    TAG_ID,
    TAG_DNR,
    TAG_LEN,
    TAG_PAYLOAD,
    TAG_GAP
  } tag_state_e;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_SEND
  } seq_state_e;

  function automatic bsg_dmc_cfg_payload_s pack_cfg_payload(input bsg_dmc_s dmc,
                                                            input logic     sys_reset,
                                                            input logic     stall);
    bsg_dmc_cfg_payload_s p;
    p[0]  = dmc.trefi[7:0];
    p[1]  = dmc.trefi[15:8];
    p[2]  = {dmc.trfc, dmc.tmrd};
    p[3]  = {dmc.trp, dmc.trc};
    p[4]  = {dmc.trrd, dmc.tras};
    p[5]  = {dmc.twr, dmc.trcd};
    p[6]  = {dmc.trtp, dmc.twtr};
    p[7]  = {1'b0, dmc.dqs_sel_cal, dmc.tcas};
    p[8]  = {dmc.row_width, dmc.col_width};
    p[9]  = {dmc.bank_pos, dmc.bank_width};
    p[10] = dmc.init_cycles[7:0];
    p[11] = dmc.init_cycles[15:8];
    p[dmc_cfg_sys_reset_node_c] = {7'b0, sys_reset};
    p[dmc_cfg_stall_node_c]     = {7'b0, stall};
    return p;
  endfunction

endpackage

// File: rtl/bsg_dmc_tag_packet_serializer.sv
// Sends one bsg_tag packet (start, id, data_not_reset, length, payload, gap),
// every field LSB first; accepts the next packet during its final gap bit.
module bsg_dmc_tag_packet_serializer
  import bsg_dmc_pkg::*;
#(
  parameter int id_width_p   = 4,
  parameter int len_width_p  = 4,
  parameter int gap_cycles_p = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  v_i,
  output logic                  ready_o,
  input  logic [id_width_p-1:0] id_i,
  input  logic                  dnr_i,
  input  logic [7:0]            payload_i,
  output logic                  tag_data_o,
  output logic                  done_o
);

  localparam logic [len_width_p-1:0] len_c = len_width_p'(dmc_cfg_payload_width_c);
  localparam logic [7:0] id_last_c   = 8'(id_width_p - 1);
  localparam logic [7:0] len_last_c  = 8'(len_width_p - 1);
  localparam logic [7:0] pay_last_c  = 8'(dmc_cfg_payload_width_c - 1);
  localparam logic [7:0] gap_last_c  = 8'(gap_cycles_p - 1);

  tag_state_e            state_reg;
  logic [7:0]            cnt_reg;
  logic [7:0]            sh_reg;
  logic [id_width_p-1:0] id_reg;
  logic                  dnr_reg;
  logic [7:0]            payload_reg;
  logic                  data_reg;

  assign done_o     = (state_reg == TAG_GAP) && (cnt_reg == gap_last_c);
  assign ready_o    = (state_reg == TAG_IDLE) || done_o;
  assign tag_data_o = data_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg   <= TAG_IDLE;
      cnt_reg     <= '0;
      sh_reg      <= '0;
      id_reg      <= '0;
      dnr_reg     <= 1'b0;
      payload_reg <= '0;
      data_reg    <= 1'b0;
    end else if (v_i && ready_o) begin
      state_reg   <= TAG_START;
      data_reg    <= 1'b1;
      id_reg      <= id_i;
      dnr_reg     <= dnr_i;
      payload_reg <= payload_i;
      cnt_reg     <= '0;
    end else begin
      case (state_reg)
        TAG_START: begin
          data_reg  <= id_reg[0];
          sh_reg    <= 8'(id_reg >> 1);
          cnt_reg   <= '0;
          state_reg <= TAG_ID;
        end
        TAG_ID: begin
          if (cnt_reg == id_last_c) begin
            data_reg  <= dnr_reg;
            state_reg <= TAG_DNR;
          end else begin
            data_reg <= sh_reg[0];
            sh_reg   <= sh_reg >> 1;
            cnt_reg  <= cnt_reg + 8'd1;
          end
        end
        TAG_DNR: begin
          data_reg  <= len_c[0];
          sh_reg    <= 8'(len_c >> 1);
          cnt_reg   <= '0;
          state_reg <= TAG_LEN;
        end
        TAG_LEN: begin
          if (cnt_reg == len_last_c) begin
            data_reg  <= payload_reg[0];
            sh_reg    <= payload_reg >> 1;
            cnt_reg   <= '0;
            state_reg <= TAG_PAYLOAD;
          end else begin
            data_reg <= sh_reg[0];
            sh_reg   <= sh_reg >> 1;
            cnt_reg  <= cnt_reg + 8'd1;
          end
        end
        TAG_PAYLOAD: begin
          if (cnt_reg == pay_last_c) begin
            data_reg  <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= TAG_GAP;
          end else begin
            data_reg <= sh_reg[0];
            sh_reg   <= sh_reg >> 1;
            cnt_reg  <= cnt_reg + 8'd1;
          end
        end
        TAG_GAP: begin
          data_reg <= 1'b0;
          if (cnt_reg == gap_last_c) begin
            state_reg <= TAG_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: begin
          data_reg  <= 1'b0;
          state_reg <= TAG_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/bsg_dmc_tag_cfg_sender.sv
// Packs a bsg_dmc_s config into node payloads and sends one tag packet per selected
// node in ascending order. BSG_DMC_TAG_CFG_SENDER_RESET_EN prefixes each with a reset packet.
module bsg_dmc_tag_cfg_sender
  import bsg_dmc_pkg::*;
#(
  parameter int num_nodes_p      = dmc_cfg_num_nodes_c,
  parameter int node_id_offset_p = 0,
  parameter int node_id_width_p  = 4,
  parameter int len_width_p      = 4,
  parameter int gap_cycles_p     = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  output logic                   ready_o,
  input  bsg_dmc_s               dmc_p_i,
  input  logic                   sys_reset_i,
  input  logic                   stall_transmission_i,
  input  logic [num_nodes_p-1:0] node_mask_i,
  output logic                   tag_data_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int idx_w_c = (num_nodes_p > 1) ? $clog2(num_nodes_p) : 1;

`ifdef BSG_DMC_TAG_CFG_SENDER_RESET_EN
  localparam logic first_phase_c = 1'b0;
`else
  localparam logic first_phase_c = 1'b1;
`endif

  seq_state_e           state_reg;
  logic [num_nodes_p-1:0] rem_reg;
  logic [idx_w_c-1:0]   cur_reg;
  logic                 data_phase_reg;
  bsg_dmc_cfg_payload_s payload_reg;
  logic                 busy_reg;
  logic                 done_reg;

  bsg_dmc_cfg_payload_s payload_live;
  bsg_dmc_cfg_payload_s payload_src;
  logic [num_nodes_p-1:0] scan_src;
  logic [idx_w_c-1:0]   next_idx;
  logic [idx_w_c-1:0]   sel_idx;
  logic                 any_next;
  logic                 use_cur;
  logic                 more;
  logic                 ser_v;
  logic                 ser_ready;
  logic                 ser_done;
  logic                 ser_dnr;
  logic [node_id_width_p-1:0] ser_id;
  logic [7:0]           ser_payload;

  assign payload_live = pack_cfg_payload(dmc_p_i, sys_reset_i, stall_transmission_i);
  assign payload_src  = (state_reg == SEQ_IDLE) ? payload_live : payload_reg;

  // Lowest selected node still pending; the raw mask is scanned on the accept cycle.
  always_comb begin
    scan_src = (state_reg == SEQ_IDLE) ? node_mask_i : rem_reg;
    next_idx = '0;
    any_next = 1'b0;
    for (int i = num_nodes_p - 1; i >= 0; i--) begin
      if (scan_src[i]) begin
        next_idx = idx_w_c'(i);
        any_next = 1'b1;
      end
    end
  end

  // A reset packet is in flight, so the data packet for the same node goes next.
  assign use_cur     = (state_reg == SEQ_SEND) && !data_phase_reg;
  assign more        = use_cur || any_next;
  assign sel_idx     = use_cur ? cur_reg : next_idx;
  assign ser_dnr     = use_cur || first_phase_c;
  assign ser_id      = node_id_width_p'(node_id_offset_p + int'(sel_idx));
  assign ser_payload = ser_dnr ? payload_src[sel_idx] : 8'hFF;
  assign ser_v       = (state_reg == SEQ_IDLE) ? (v_i && any_next && ser_ready)
                                               : (ser_ready && more);

  bsg_dmc_tag_packet_serializer #(
    .id_width_p   (node_id_width_p),
    .len_width_p  (len_width_p),
    .gap_cycles_p (gap_cycles_p)
  ) serializer (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .v_i        (ser_v),
    .ready_o    (ser_ready),
    .id_i       (ser_id),
    .dnr_i      (ser_dnr),
    .payload_i  (ser_payload),
    .tag_data_o (tag_data_o),
    .done_o     (ser_done)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg      <= SEQ_IDLE;
      rem_reg        <= '0;
      cur_reg        <= '0;
      data_phase_reg <= 1'b0;
      payload_reg    <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        SEQ_IDLE: begin
          if (v_i) begin
            payload_reg    <= payload_live;
            rem_reg        <= node_mask_i & ~(num_nodes_p'(1) << next_idx);
            cur_reg        <= next_idx;
            data_phase_reg <= first_phase_c;
            if (any_next) begin
              state_reg <= SEQ_SEND;
              busy_reg  <= 1'b1;
            end else begin
              done_reg <= 1'b1;
            end
          end
        end
        SEQ_SEND: begin
          if (ser_done) begin
            if (more) begin
              if (use_cur) begin
                data_phase_reg <= 1'b1;
              end else begin
                rem_reg        <= rem_reg & ~(num_nodes_p'(1) << next_idx);
                cur_reg        <= next_idx;
                data_phase_reg <= first_phase_c;
              end
            end else begin
              state_reg <= SEQ_IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= SEQ_IDLE;
      endcase
    end
  end

  assign busy_o  = busy_reg;
  assign done_o  = done_reg;
  assign ready_o = !busy_reg;

endmodule

// File: tb/tb_bsg_dmc_tag_cfg_sender.sv
// Scoreboard bench: each accept pushes the expected per-cycle line/done/busy trace built
// from the node payload rules; a negedge monitor pops and compares every cycle.
`timescale 1ns/1ps
module tb_bsg_dmc_tag_cfg_sender;
  import bsg_dmc_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        v = 1'b0;
  logic        sys_reset = 1'b0;
  logic        stall = 1'b0;
  bsg_dmc_s    dmc = '0;
  logic [13:0] mask = '0;
  logic        ready, tag, busy, done;

  always #5 clk = ~clk;

  bsg_dmc_tag_cfg_sender dut (
    .clk_i                (clk),
    .reset_n_i            (reset_n),
    .v_i                  (v),
    .ready_o              (ready),
    .dmc_p_i              (dmc),
    .sys_reset_i          (sys_reset),
    .stall_transmission_i (stall),
    .node_mask_i          (mask),
    .tag_data_o           (tag),
    .busy_o               (busy),
    .done_o               (done)
  );

  typedef struct {
    bit tag;
    bit done;
    bit busy;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_done_cyc = -1;
  int accept_cyc = 0;
  int exp_latency = 0;
  int n_accepts = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  // Reference payload per node, from the field layout with plain arithmetic.
  function automatic int cfg_byte(input int i);
    case (i)
      0:  return int'(dmc.trefi) % 256;
      1:  return int'(dmc.trefi) / 256;
      2:  return int'(dmc.trfc) * 16 + int'(dmc.tmrd);
      3:  return int'(dmc.trp) * 16 + int'(dmc.trc);
      4:  return int'(dmc.trrd) * 16 + int'(dmc.tras);
      5:  return int'(dmc.twr) * 16 + int'(dmc.trcd);
      6:  return int'(dmc.trtp) * 16 + int'(dmc.twtr);
      7:  return int'(dmc.dqs_sel_cal) * 16 + int'(dmc.tcas);
      8:  return int'(dmc.row_width) * 16 + int'(dmc.col_width);
      9:  return int'(dmc.bank_pos) * 4 + int'(dmc.bank_width);
      10: return int'(dmc.init_cycles) % 256;
      11: return int'(dmc.init_cycles) / 256;
      12: return int'(sys_reset);
      default: return int'(stall);
    endcase
  endfunction

  function automatic void push_bits(input int val, input int n);
    exp_t e;
    for (int b = 0; b < n; b++) begin
      e.tag  = ((val >> b) & 1) != 0;
      e.done = 1'b0;
      e.busy = 1'b1;
      q.push_back(e);
    end
  endfunction

  function automatic void push_packet(input int id, input int dnr, input int payload);
    push_bits(1, 1);
    push_bits(id, 4);
    push_bits(dnr, 1);
    push_bits(8, 4);
    push_bits(payload, 8);
    push_bits(0, 2);
  endfunction

  // Pushes the whole expected trace of one transfer; returns the cycle of done.
  function automatic int push_transfer();
    exp_t e;
    int   pkts = 0;
    for (int i = 0; i < 14; i++) begin
      if (mask[i]) begin
`ifdef BSG_DMC_TAG_CFG_SENDER_RESET_EN
        push_packet(i, 0, 255);
        pkts++;
`endif
        push_packet(i, 1, cfg_byte(i));
        pkts++;
      end
    end
    e.tag  = 1'b0;
    e.done = 1'b1;
    e.busy = 1'b0;
    q.push_back(e);
    return pkts * 20 + 1;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      check("reset_state", 32'({tag, done, busy, ready}), 32'h1);
    end else begin
      e.tag  = 1'b0;
      e.done = 1'b0;
      e.busy = 1'b0;
      if (q.size() > 0) e = q.pop_front();
      check("stream_tag_done_busy_ready", 32'({tag, done, busy, ready}),
            32'({e.tag, e.done, e.busy, !e.busy}));
      if (done) last_done_cyc = cyc;
    end
  end

  // One clock; entered and left at posedge+1. Predicts the accept from the model's busy.
  task automatic step();
    bit acc;
    acc = reset_n && v && (q.size() == 0 || !q[0].busy);
    @(posedge clk);
    if (acc) begin
      exp_latency = push_transfer();
      #1;
      accept_cyc = cyc;
      n_accepts++;
      $display("accept %0d at cycle %0d mask=%h sys_reset=%0d stall=%0d trefi=%h expect_done_in=%0d",
               n_accepts, cyc, mask, sys_reset, stall, dmc.trefi, exp_latency);
    end else begin
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    v = 1'b0;
    while (q.size() > 0 && n < 2000) begin
      step();
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d entries left, required 0", q.size());
      q.delete();
    end
    step();
  endtask

  task automatic rand_cfg();
    dmc.trefi       = 16'($urandom);
    dmc.tmrd        = 4'($urandom);
    dmc.trfc        = 4'($urandom);
    dmc.trc         = 4'($urandom);
    dmc.trp         = 4'($urandom);
    dmc.tras        = 4'($urandom);
    dmc.trrd        = 4'($urandom);
    dmc.trcd        = 4'($urandom);
    dmc.twr         = 4'($urandom);
    dmc.twtr        = 4'($urandom);
    dmc.trtp        = 4'($urandom);
    dmc.tcas        = 4'($urandom);
    dmc.col_width   = 4'($urandom);
    dmc.row_width   = 4'($urandom);
    dmc.bank_width  = 2'($urandom);
    dmc.bank_pos    = 6'($urandom);
    dmc.dqs_sel_cal = 3'($urandom);
    dmc.init_cycles = 16'($urandom);
    sys_reset       = 1'($urandom);
    stall           = 1'($urandom);
  endtask

  task automatic directed(input logic [13:0] m);
    mask = m;
    last_done_cyc = -1;
    v = 1'b1;
    step();
    v = 1'b0;
    drain();
    check("done_latency", 32'(last_done_cyc - accept_cyc + 1), 32'(exp_latency));
  endtask

  initial begin
    int target;
    int n;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step();

    // Full mask with trefi 0x1234.
    rand_cfg();
    dmc.trefi = 16'h1234;
    directed(14'h3fff);

    // Single node 7: tcas=5, dqs_sel_cal=3 gives payload 0x35.
    rand_cfg();
    dmc.tcas = 4'h5;
    dmc.dqs_sel_cal = 3'h3;
    directed(14'b1 << 7);

    // Empty mask: done one cycle after accept, no line activity.
    rand_cfg();
    directed(14'h0);

    // Single node 0.
    rand_cfg();
    directed(14'h1);

    // Asynchronous reset in the middle of the node 3 payload.
    rand_cfg();
    mask = 14'h3fff;
    v = 1'b1;
    step();
    v = 1'b0;
    repeat (73) step();
    #2 reset_n = 1'b0;
    q.delete();
    #1 check("async_reset_outputs", 32'({tag, done, busy, ready}), 32'h1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    rand_cfg();
    directed(14'($urandom));

    // v held high: sys_reset/stall nodes, second accept lands in the done cycle.
    rand_cfg();
    sys_reset = 1'b1;
    stall = 1'b1;
    mask = 14'h3000;
    v = 1'b1;
    target = n_accepts + 2;
    n = 0;
    while (n_accepts < target && n < 400) begin
      step();
      n++;
    end
    check("back_to_back_accepts", 32'(n_accepts), 32'(target));
    drain();

    // Random transfers with v noise and input churn while busy.
    for (int t = 0; t < 6; t++) begin
      rand_cfg();
      case ($urandom_range(0, 3))
        0: mask = 14'h0;
        1: mask = 14'h3fff;
        default: mask = 14'($urandom);
      endcase
      v = 1'b1;
      step();
      repeat (30) begin
        v = 1'($urandom);
        rand_cfg();
        mask = 14'($urandom);
        step();
      end
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
